// File: rtl/prelu_map_sequencer.sv
// PReLU sequencer: streams one channel from a source RAM through y = x<0 ? (x*alpha)>>>FRAC_W : x into a destination RAM.
// Build option PRELU_SAT_EN: when defined, negative-path results saturate to DATA_W; otherwise they wrap.
module prelu_map_sequencer #(
    parameter int                DATA_W        = 16,
    parameter int                FRAC_W        = 8,
    parameter int                ADDR_W        = 12,
    parameter int                NUM_CH        = 64,
    parameter int                CH_W          = 6,
    parameter logic [DATA_W-1:0] DEFAULT_ALPHA = 16'h0040
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start,
    input  logic [CH_W-1:0]   ch_in,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W-1:0] len_in,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DATA_W-1:0] cfg_alpha,
    output logic              cfg_rej
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         src_q, dst_q, len_q, cnt_q;
    logic signed [DATA_W-1:0]  alpha_q;
    logic [DATA_W-1:0]         alpha_rf_q [NUM_CH];
    logic                      vld_p0_q;
    logic [ADDR_W-1:0]         waddr_p0_q;
    logic                      wr_en_q;
    logic [ADDR_W-1:0]         wr_addr_q;
    logic [DATA_W-1:0]         wr_data_q;
    logic                      cfg_rej_q;

    function automatic logic [DATA_W-1:0] reduce_w(input logic signed [2*DATA_W-1:0] v);
`ifdef PRELU_SAT_EN
        logic signed [2*DATA_W-1:0] smax;
        logic signed [2*DATA_W-1:0] smin;
        smax = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
        smin = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
        if (v > smax) return smax[DATA_W-1:0];
        if (v < smin) return smin[DATA_W-1:0];
        return v[DATA_W-1:0];
`else
        return v[DATA_W-1:0];
`endif
    endfunction

    function automatic logic [DATA_W-1:0] prelu(input logic signed [DATA_W-1:0] x,
                                                input logic signed [DATA_W-1:0] a);
        logic signed [2*DATA_W-1:0] p;
        if (x >= 0) return x;
        p = (2*DATA_W)'(x) * (2*DATA_W)'(a);
        return reduce_w(p >>> FRAC_W);
    endfunction

    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (len_in == '0) ? FINISH : RUN;
            RUN:     if (cnt_q == len_q - 1'b1) state_d = DRAIN;
            DRAIN:   if (!vld_p0_q) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == RUN) || (state_q == DRAIN);
        done  = (state_q == FINISH);
        rd_en = (state_q == RUN);
    end

    assign rd_addr = src_q + cnt_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign cfg_rej = cfg_rej_q;

    // Coefficient writes only land while idle; the run samples its alpha at start.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int k = 0; k < NUM_CH; k++) alpha_rf_q[k] <= DEFAULT_ALPHA;
        end else if (cfg_we && state_q == IDLE && int'(cfg_ch) < NUM_CH) begin
            alpha_rf_q[cfg_ch] <= cfg_alpha;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            alpha_q    <= DEFAULT_ALPHA;
            vld_p0_q   <= 1'b0;
            waddr_p0_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cfg_rej_q  <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                src_q   <= src_base;
                dst_q   <= dst_base;
                len_q   <= len_in;
                cnt_q   <= '0;
                alpha_q <= alpha_rf_q[ch_in];
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // p0: read issued, RAM data arrives next cycle
            vld_p0_q   <= rd_en;
            waddr_p0_q <= dst_q + cnt_q;
            // p1: registered PReLU result drives the destination RAM
            wr_en_q <= vld_p0_q;
            if (vld_p0_q) begin
                wr_addr_q <= waddr_p0_q;
                wr_data_q <= prelu(rd_data, alpha_q);
            end
            cfg_rej_q <= cfg_we && (state_q != IDLE);
        end
    end

endmodule

// File: tb/tb_prelu_map_sequencer.sv
// Directed bench for prelu_map_sequencer: scoreboard of expected RAM writes plus per-cycle handshake checks.
module tb_prelu_map_sequencer;

    localparam int DW = 16;
    localparam int AW = 12;
    localparam int CW = 6;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          start;
    logic [CW-1:0] ch_in;
    logic [AW-1:0] src_base, dst_base, len_in;
    logic          busy, done, rd_en, wr_en, cfg_rej;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] wr_data;
    logic          cfg_we;
    logic [CW-1:0] cfg_ch;
    logic [DW-1:0] cfg_alpha;

    logic [DW-1:0] src_mem [0:4095];
    logic [DW-1:0] dst_mem [0:4095];
    logic [DW-1:0] alpha_model [0:63];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sbq[$];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    prelu_map_sequencer dut (
        .clk_in(clk_in), .rst_in(rst_in), .start(start), .ch_in(ch_in),
        .src_base(src_base), .dst_base(dst_base), .len_in(len_in),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_alpha(cfg_alpha), .cfg_rej(cfg_rej)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] xu, input logic [15:0] au);
        longint x, a, p, q;
        x = longint'($signed(xu));
        a = longint'($signed(au));
        if (x >= 0) return xu;
        p = x * a;
        q = p / 256;
        if (p < 0 && (p % 256) != 0) q = q - 1;
`ifdef PRELU_SAT_EN
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
`endif
        return q[15:0];
    endfunction

    // Source RAM with one-cycle read latency; destination RAM captures writes.
    always @(posedge clk_in) begin
        if (rd_en) rd_data <= src_mem[rd_addr];
        if (wr_en) dst_mem[wr_addr] <= wr_data;
    end

    always @(negedge clk_in) begin
        if (wr_en === 1'b1) begin
            check("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                exp_t e;
                e = sbq.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    task automatic cfg_write(input logic [CW-1:0] ch, input logic [DW-1:0] a);
        cfg_we = 1'b1; cfg_ch = ch; cfg_alpha = a;
        @(posedge clk_in); #1;
        cfg_we = 1'b0;
        alpha_model[ch] = a;
        @(negedge clk_in);
        check("cfg_rej_idle", 32'(cfg_rej), 32'd0);
        @(posedge clk_in); #1;
    endtask

    task automatic run(input logic [CW-1:0] ch, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                       input logic [AW-1:0] len, input int inj, input int abort);
        int npush, last, ilen;
        logic [AW-1:0] sa, da, ea;
        ilen  = int'(len);
        npush = (abort > 0) ? abort - 2 : ilen;
        if (npush > ilen) npush = ilen;
        if (npush < 0) npush = 0;
        for (int i = 0; i < npush; i++) begin
            sa = src + AW'(i);
            da = dst + AW'(i);
            sbq.push_back({da, model(src_mem[sa], alpha_model[ch])});
        end
        ch_in = ch; src_base = src; dst_base = dst; len_in = len; start = 1'b1;
        @(posedge clk_in); #1;
        start = 1'b0;
        last = (ilen == 0) ? 2 : ilen + 4;
        for (int c = 1; c <= last; c++) begin
            bit ab, eb, ed, er, ew;
            @(negedge clk_in);
            ab = (abort > 0) && (c > abort);
            eb = !ab && ilen != 0 && c <= ilen + 2;
            ed = !ab && c == ((ilen == 0) ? 1 : ilen + 3);
            er = !ab && c <= ilen;
            ew = !ab && ilen != 0 && c >= 3 && c <= ilen + 2;
            check("busy",  32'(busy),  32'(eb));
            check("done",  32'(done),  32'(ed));
            check("rd_en", 32'(rd_en), 32'(er));
            check("wr_en", 32'(wr_en), 32'(ew));
            if (er) begin
                ea = src + AW'(c - 1);
                check("rd_addr", 32'(rd_addr), 32'(ea));
            end
            if (inj > 0 && c == inj + 1) check("cfg_rej_busy", 32'(cfg_rej), 32'd1);
            if (c == inj) begin
                cfg_we = 1'b1; cfg_ch = 6'd3; cfg_alpha = 16'h0100;
                start = 1'b1; ch_in = 6'd0; len_in = 12'd1; src_base = 12'h000; dst_base = 12'h800;
            end
            if (c == abort) rst_in = 1'b1;
            @(posedge clk_in); #1;
            cfg_we = 1'b0; start = 1'b0; rst_in = 1'b0;
        end
        if (abort > 0) for (int k = 0; k < 64; k++) alpha_model[k] = 16'h0040;
        check("sb_drained", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) src_mem[i] = '0;
        for (int k = 0; k < 64; k++) alpha_model[k] = 16'h0040;
        rst_in = 1'b1; start = 1'b0; ch_in = '0; src_base = '0; dst_base = '0; len_in = '0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_alpha = '0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_done",    32'(done),    32'd0);
        check("rst_rd_en",   32'(rd_en),   32'd0);
        check("rst_wr_en",   32'(wr_en),   32'd0);
        check("rst_cfg_rej", 32'(cfg_rej), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        @(posedge clk_in); #1;

        // Basic run on channel 3
        src_mem[0] = 16'hFF00; src_mem[1] = 16'd300; src_mem[2] = 16'hFFFD; src_mem[3] = 16'h0000;
        cfg_write(6'd3, 16'h0040);
        run(6'd3, 12'h000, 12'h100, 12'd4, 0, 0);
        check("c1_d0", 32'(dst_mem[12'h100]), 32'h0000FFC0);
        check("c1_d1", 32'(dst_mem[12'h101]), 32'h0000012C);
        check("c1_d2", 32'(dst_mem[12'h102]), 32'h0000FFFF);
        check("c1_d3", 32'(dst_mem[12'h103]), 32'h00000000);

        // Zero-length run
        run(6'd3, 12'h000, 12'h500, 12'd0, 0, 0);

        // Overflow on the negative path
        cfg_write(6'd0, 16'h7FFF);
        src_mem[12'h010] = 16'h8000;
        run(6'd0, 12'h010, 12'h200, 12'd1, 0, 0);
`ifdef PRELU_SAT_EN
        check("ovf", 32'(dst_mem[12'h200]), 32'h00008000);
`else
        check("ovf", 32'(dst_mem[12'h200]), 32'h00000080);
`endif

        // Config write and start while busy are dropped
        src_mem[12'h020] = 16'hFC18; src_mem[12'h021] = 16'd5;     src_mem[12'h022] = 16'h8000;
        src_mem[12'h023] = 16'h7FFF; src_mem[12'h024] = 16'hFFF9; src_mem[12'h025] = 16'h0000;
        src_mem[12'h026] = 16'hFFFF; src_mem[12'h027] = 16'd100;
        run(6'd3, 12'h020, 12'h300, 12'd8, 3, 0);
        run(6'd3, 12'h000, 12'h110, 12'd4, 0, 0);
        check("rerun_d0", 32'(dst_mem[12'h110]), 32'h0000FFC0);
        check("rerun_d2", 32'(dst_mem[12'h112]), 32'h0000FFFF);

        // Reset mid-run restores default coefficients
        run(6'd3, 12'h020, 12'h600, 12'd8, 0, 4);
        @(negedge clk_in);
        check("abort_busy", 32'(busy), 32'd0);
        @(posedge clk_in); #1;
        run(6'd0, 12'h000, 12'h400, 12'd1, 0, 0);
        check("dflt_alpha0", 32'(dst_mem[12'h400]), 32'h0000FFC0);

        // Address wrap
        src_mem[12'hFFE] = 16'hFE00; src_mem[12'hFFF] = 16'd7;
        run(6'd3, 12'hFFE, 12'hFFF, 12'd3, 0, 0);
        check("wrap_d0", 32'(dst_mem[12'hFFF]), 32'h0000FF80);
        check("wrap_d1", 32'(dst_mem[12'h000]), 32'h00000007);
        check("wrap_d2", 32'(dst_mem[12'h001]), 32'h0000FFC0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
